// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Multi-channel interrupt controller sitting in front of the fetch stage.
// Rising edges on irq_in are latched into a pending register. The lowest-index
// unmasked pending channel wins. Its request and vector address are held until
// the pipeline acknowledges them. Further requests are then blocked until the
// handler's RTI retires. Interrupts do not nest.
//
// Parameters
//   NUM_CH      number of interrupt sources (1..16)
//   ADDR_W      vector address width
//   VEC_BASE    vector address of channel 0
//   VEC_STRIDE  address distance between consecutive channel vectors
//   ID_W        channel id width
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   irq_in        synchronous interrupt lines, bit i = channel i
//   mask_wr_en    load mask_wr_data into the mask register
//   mask_wr_data  new mask, 1 = channel masked
//   irq_ack       pipeline has taken the outstanding request
//   rti_done      one-cycle pulse when the handler's RTI retires
//   irq_req       interrupt request to the pipeline
//   irq_vector    service-routine address, valid while irq_req=1
//   irq_id        winning channel, valid while irq_req=1 or busy=1
//   busy          handler in progress
//   pending       latched edges that have not yet been serviced
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int VEC_BASE   = 0,
    parameter int VEC_STRIDE = 16,
    parameter int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              mask_wr_en,
    input  logic [NUM_CH-1:0] mask_wr_data,
    input  logic              irq_ack,
    input  logic              rti_done,
    output logic              irq_req,
    output logic [ADDR_W-1:0] irq_vector,
    output logic [ID_W-1:0]   irq_id,
    output logic              busy,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [NUM_CH-1:0] prev_reg;
    logic [NUM_CH-1:0] pending_reg, pending_next;
    logic [NUM_CH-1:0] mask_reg, mask_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [ADDR_W-1:0] vector_reg, vector_next;

    logic [NUM_CH-1:0] edge_vec;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] clr_vec;
    logic [ID_W-1:0]   win_id;
    logic              ack_fire;

    // Constant mask of all channels whose index has bit b set. Used to turn
    // the one-hot grant into a binary id without any priority chain.
    function automatic logic [NUM_CH-1:0] id_bit_mask(input int b);
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m = m | (NUM_CH'((c >> b) & 1) << c);
        end
        return m;
    endfunction

    // A level held high only produces an event on the sample where it rises.
    // prev_reg resets to 0, so a line already high at reset release counts.
    assign edge_vec = irq_in & ~prev_reg;

    // Masked channels keep their pending bit but cannot win arbitration.
    assign eligible = pending_reg & ~mask_reg;

    // Isolate the lowest set bit: fixed priority, channel 0 highest.
    assign grant = eligible & (~eligible + NUM_CH'(1));

    generate
        for (genvar gi = 0; gi < ID_W; gi++) begin : g_win_id
            assign win_id[gi] = |(grant & id_bit_mask(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        vector_next = vector_reg;
        ack_fire    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|eligible) begin
                    state_next  = ST_REQ;
                    id_next     = win_id;
                    vector_next = ADDR_W'(VEC_BASE) + ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);
                end
            end
            ST_REQ: begin
                // Once raised the request is held unconditionally; masking or
                // a higher-priority edge cannot withdraw it.
                if (irq_ack) begin
                    state_next = ST_SERVICE;
                    ack_fire   = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (rti_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Clear the serviced channel on ack. A new edge on that same channel in
    // the same cycle is ORed in afterwards so it is not lost.
    assign clr_vec      = ack_fire ? (NUM_CH'(1) << id_reg) : '0;
    assign pending_next = (pending_reg & ~clr_vec) | edge_vec;
    assign mask_next    = mask_wr_en ? mask_wr_data : mask_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            prev_reg    <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
            id_reg      <= '0;
            vector_reg  <= ADDR_W'(VEC_BASE);
        end else begin
            state_reg   <= state_next;
            prev_reg    <= irq_in;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            id_reg      <= id_next;
            vector_reg  <= vector_next;
        end
    end

    assign irq_req    = (state_reg == ST_REQ);
    assign busy       = (state_reg == ST_SERVICE);
    assign irq_id     = id_reg;
    assign irq_vector = vector_reg;
    assign pending    = pending_reg;

endmodule
